// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared Zicsr encodings, machine CSR addresses and sequencer states
package csr_pkg;

    // Full funct3 encodings of the Zicsr instructions
    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    // funct3[1:0] selects the operation; funct3[2] selects the immediate operand
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    // Machine CSRs implemented by the register file
    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;

    // Inclusive bounds of the read-only identification block
    localparam logic [11:0] CSR_RO_LO = 12'hF11;
    localparam logic [11:0] CSR_RO_HI = 12'hF14;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Value written back for a read-modify-write, given the old CSR contents
    function automatic logic [31:0] csr_new_value(
        input logic [1:0]  op,
        input logic [31:0] old_val,
        input logic [31:0] operand
    );
        logic [31:0] result;
        case (op)
            OP_RS:   result = old_val | operand;
            OP_RC:   result = old_val & ~operand;
            default: result = operand;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_addr_check.sv
// rtl/csr_addr_check.sv - classifies a 12-bit CSR address as implemented and/or read-only
module csr_addr_check
    import csr_pkg::*;
(
    input  logic [11:0] addr_i,
    output logic        legal_o,
    output logic        read_only_o
);

    // Decode the address against the implemented CSR list and the read-only block
    always_comb begin
        read_only_o = (addr_i >= CSR_RO_LO) && (addr_i <= CSR_RO_HI);
        case (addr_i)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC,
            CSR_MCOUNTEREN, CSR_MEPC, CSR_MCAUSE, CSR_MIP,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH,
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID:
                legal_o = 1'b1;
            default:
                legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - sequences one Zicsr read-modify-write against the machine CSR file
module csr_access_unit
    import csr_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_csr,
    input  logic [31:0] req_rs1_val,
    input  logic        req_rs1_zero,
    input  logic [4:0]  req_uimm,
    input  logic        req_rd_zero,
    output logic [31:0] csr_address,
    output logic        csr_en_read,
    output logic        csr_en_write,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal
);

    state_e      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_illegal_q;
    logic        en_read_q;
    logic        en_write_q;
    logic [31:0] wdata_q;
    logic [31:0] address_q;
    logic [1:0]  op_q;
    logic [31:0] operand_q;
    logic        write_req_q;
    logic [31:0] old_q;

    logic        addr_legal;
    logic        addr_read_only;
    logic [1:0]  req_op;
    logic [31:0] req_operand_d;
    logic        req_src_nonzero;
    logic        req_write_d;
    logic        req_read_skip_d;
    logic        req_illegal_d;

    csr_addr_check u_addr_check (
        .addr_i      (req_csr),
        .legal_o     (addr_legal),
        .read_only_o (addr_read_only)
    );

    // Classify the incoming request: operand source, write need, read skip, legality
    always_comb begin
        req_op          = req_funct3[1:0];
        req_operand_d   = req_funct3[2] ? {27'b0, req_uimm} : req_rs1_val;
        req_src_nonzero = req_funct3[2] ? (req_uimm != 5'd0) : !req_rs1_zero;
        req_write_d     = (req_op == OP_RW) || req_src_nonzero;
        req_read_skip_d = (req_op == OP_RW) && req_rd_zero;
        req_illegal_d   = !addr_legal
                          || (req_op == OP_NONE)
                          || (req_write_d && addr_read_only);
    end

    // Sequencer with registered strobes and response; reset aborts without a response
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_illegal_q <= 1'b0;
            en_read_q     <= 1'b0;
            en_write_q    <= 1'b0;
            wdata_q       <= 32'd0;
            address_q     <= 32'd0;
            op_q          <= OP_NONE;
            operand_q     <= 32'd0;
            write_req_q   <= 1'b0;
            old_q         <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        op_q        <= req_op;
                        operand_q   <= req_operand_d;
                        write_req_q <= req_write_d;
                        old_q       <= 32'd0;
                        address_q   <= {20'b0, req_csr};
                        if (req_illegal_d) begin
                            state_q       <= ST_RESP;
                            rsp_valid_q   <= 1'b1;
                            rsp_illegal_q <= 1'b1;
                            rsp_rdata_q   <= 32'd0;
                        end else if (req_read_skip_d) begin
                            // Only RW/RWI skip the read, so the operand is the new value
                            state_q    <= ST_WRITE;
                            en_write_q <= 1'b1;
                            wdata_q    <= req_operand_d;
                        end else begin
                            state_q   <= ST_READ;
                            en_read_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    en_read_q <= 1'b0;
                    state_q   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // File data_out is valid now, one cycle after the read strobe
                    old_q <= csr_rdata;
                    if (write_req_q) begin
                        state_q    <= ST_WRITE;
                        en_write_q <= 1'b1;
                        wdata_q    <= csr_new_value(op_q, csr_rdata, operand_q);
                    end else begin
                        state_q       <= ST_RESP;
                        rsp_valid_q   <= 1'b1;
                        rsp_illegal_q <= 1'b0;
                        rsp_rdata_q   <= csr_rdata;
                    end
                end
                ST_WRITE: begin
                    en_write_q    <= 1'b0;
                    state_q       <= ST_RESP;
                    rsp_valid_q   <= 1'b1;
                    rsp_illegal_q <= 1'b0;
                    rsp_rdata_q   <= old_q;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    en_read_q   <= 1'b0;
                    en_write_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign csr_address  = address_q;
    assign csr_en_read  = en_read_q;
    assign csr_en_write = en_write_q;
    assign csr_wdata    = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_illegal  = rsp_illegal_q;

endmodule
